// File: rtl/buffered_input_port.sv
// ----------------------------------------------------------------------------
// buffered_input_port
//
// Switch/button input port for the MIPS core's IN instruction. The raw
// push-button is synchronised and debounced. Each debounced press captures the
// switches into a DEPTH-entry FIFO. A CPU read pops one entry. If the FIFO is
// empty, the core is halted until an entry arrives, so presses may be made
// ahead of the reads that consume them.
//
// Ports
//   clock            in   1               system clock, rising edge
//   reset_n          in   1               asynchronous active-low reset
//   button           in   1               raw push-button level (asynchronous)
//   switches         in   WIDTH           raw switch levels, sampled on a press
//   output_enable    in   1               core executing IN
//   halt_from_input  out  1               registered; 1 = stall the core
//   output_value     out  WIDTH           registered; last popped value
//   count            out  clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
//   overflow         out  1               1-cycle pulse: press dropped, FIFO full
// ----------------------------------------------------------------------------
module buffered_input_port #(
    parameter int WIDTH           = 18,
    parameter int DEPTH           = 4,     // power of two, >= 2
    parameter int DEBOUNCE_CYCLES = 50000  // >= 1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    button,
    input  logic [WIDTH-1:0]        switches,
    input  logic                    output_enable,
    output logic                    halt_from_input,
    output logic [WIDTH-1:0]        output_value,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    // The counter only ever reaches DEBOUNCE_CYCLES-1.
    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             btn_meta;
    logic             btn_s;
    logic             stable;
    logic [DB_W-1:0]  db_cnt;
    logic             press;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic             full;
    logic             pop;
    logic             push_ok;

    // ------------------------------------------------------------------
    // Synchroniser, debouncer and press detector.
    // The synchroniser and debounced level reset to "pressed" so a button
    // held through reset is not taken as a press: a release must be
    // accepted first.
    // ------------------------------------------------------------------
    // NOTE: every clocked block uses non-blocking assignments so all flops
    // update from the same pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            btn_meta <= 1'b1;
            btn_s    <= 1'b1;
            stable   <= 1'b1;
            db_cnt   <= '0;
            press    <= 1'b0;
        end else begin
            btn_meta <= button;
            btn_s    <= btn_meta;
            press    <= 1'b0;
            if (btn_s != stable) begin
                if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    // Level held long enough: accept it. Only a 0->1 change
                    // produces a press; a release merely re-arms.
                    stable <= btn_s;
                    db_cnt <= '0;
                    press  <= btn_s;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO control.
    // A pop frees a slot in the same edge, so a press that coincides with
    // a pop on a full FIFO is still accepted. On an empty FIFO the pop
    // fails even if a push lands in that edge.
    // ------------------------------------------------------------------
    assign full    = (count == CNT_W'(DEPTH));
    assign pop     = output_enable && (count != '0);
    assign push_ok = press && (!full || pop);

    // NOTE: the storage array has no reset; occupancy and pointers alone
    // decide which entries are valid, so stale contents are never observed.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= switches;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            output_value    <= '0;
            halt_from_input <= 1'b0;
            overflow        <= 1'b0;
        end else begin
            overflow        <= press && full && !pop;
            // Stall only while the core is asking and nothing could be popped.
            halt_from_input <= output_enable && !pop;

            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end

            if (pop) begin
                // On a full FIFO with a coincident push, wr_ptr == rd_ptr:
                // this reads the old entry while the new one overwrites it.
                output_value <= mem[rd_ptr];
                rd_ptr       <= rd_ptr + PTR_W'(1);
            end

            if (push_ok && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push_ok) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule
